// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, waits on mem_ready,
// and traps on illegal opcodes or memory timeouts (sticky flags).
// Optional feature: define MC_CONTROL_JR_EN to decode R-type funct 0x08 as JR.
module multicycle_control #(
  parameter int OP_WIDTH    = 6,
  parameter int ALUOP_WIDTH = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_WIDTH-1:0]    opcode,
  input  logic [OP_WIDTH-1:0]    funct,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   ir_write,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic [1:0]             reg_dst,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic [1:0]             pc_source,
  output logic [3:0]             state,
  output logic                   illegal_op,
  output logic                   bus_error
);

`ifdef MC_CONTROL_JR_EN
  localparam bit JR_ENABLE = 1'b1;
`else
  localparam bit JR_ENABLE = 1'b0;
`endif

  // Opcodes and the JR funct code
  localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'h00);
  localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'h02);
  localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(6'h03);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'h04);
  localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(6'h05);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'h08);
  localparam logic [OP_WIDTH-1:0] OP_ANDI = OP_WIDTH'(6'h0c);
  localparam logic [OP_WIDTH-1:0] OP_ORI  = OP_WIDTH'(6'h0d);
  localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(6'h0f);
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'h23);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'h2b);
  localparam logic [OP_WIDTH-1:0] FN_JR   = OP_WIDTH'(6'h08);

  // ALU operation codes
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(3'b100);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(3'b010);
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR    = ALUOP_WIDTH'(3'b001);
  localparam logic [ALUOP_WIDTH-1:0] ALU_AND   = ALUOP_WIDTH'(3'b000);
  localparam logic [ALUOP_WIDTH-1:0] ALU_LUI   = ALUOP_WIDTH'(3'b101);
  localparam logic [ALUOP_WIDTH-1:0] ALU_RTYPE = ALUOP_WIDTH'(3'b111);

  // Wait counter sized for MEM_TIMEOUT; a zero timeout still needs one bit
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t                state_q;
  state_t                decode_next;
  logic                  decode_illegal;
  logic [OP_WIDTH-1:0]   op_q;
  logic [CW-1:0]         wait_cnt;
  logic                  illegal_q;
  logic                  bus_error_q;
  logic                  waiting;
  logic                  timeout_hit;
  logic                  is_jr;
  logic [ALUOP_WIDTH-1:0] imm_alu_op;

  logic pc_write_raw;
  logic ir_write_raw;
  logic mem_read_raw;
  logic mem_write_raw;
  logic reg_write_raw;

  // A memory-facing state is waiting when the access has not completed yet;
  // a mem_ready on the limit cycle completes the access instead of trapping.
  assign waiting     = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                       && !mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LIMIT);
  assign is_jr       = JR_ENABLE && (funct == FN_JR);

  // Opcode decode used for the DECODE -> execute-state transition
  always_comb begin
    decode_next    = S_TRAP;
    decode_illegal = 1'b1;
    case (opcode)
      OP_R: begin
        decode_illegal = 1'b0;
        decode_next    = is_jr ? S_JR : S_R_EXEC;
      end
      OP_LW, OP_SW: begin
        decode_illegal = 1'b0;
        decode_next    = S_MEM_ADDR;
      end
      OP_BEQ, OP_BNE: begin
        decode_illegal = 1'b0;
        decode_next    = S_BRANCH;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
        decode_illegal = 1'b0;
        decode_next    = S_I_EXEC;
      end
      OP_J: begin
        decode_illegal = 1'b0;
        decode_next    = S_JUMP;
      end
      OP_JAL: begin
        decode_illegal = 1'b0;
        decode_next    = S_JAL;
      end
      default: begin
        decode_illegal = 1'b1;
        decode_next    = S_TRAP;
      end
    endcase
  end

  // ALU operation for the immediate-format instructions, from the latched opcode
  always_comb begin
    imm_alu_op = ALU_ADD;
    case (op_q)
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ORI:  imm_alu_op = ALU_OR;
      OP_LUI:  imm_alu_op = ALU_LUI;
      default: imm_alu_op = ALU_ADD;
    endcase
  end

  // State register, latched opcode, memory wait counter and sticky trap flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      wait_cnt    <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      if (waiting) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
      case (state_q)
        S_FETCH: begin
          if (timeout_hit) begin
            state_q     <= S_TRAP;
            bus_error_q <= 1'b1;
          end else if (mem_ready) begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_q    <= opcode;
          state_q <= decode_next;
          if (decode_illegal) begin
            illegal_q <= 1'b1;
          end
        end
        S_MEM_ADDR: state_q <= (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (timeout_hit) begin
            state_q     <= S_TRAP;
            bus_error_q <= 1'b1;
          end else if (mem_ready) begin
            state_q <= S_MEM_WB;
          end
        end
        S_MEM_WR: begin
          if (timeout_hit) begin
            state_q     <= S_TRAP;
            bus_error_q <= 1'b1;
          end else if (mem_ready) begin
            state_q <= S_FETCH;
          end
        end
        S_R_EXEC: state_q <= S_R_WB;
        S_I_EXEC: state_q <= S_I_WB;
        S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_q <= S_FETCH;
        S_TRAP:   state_q <= S_TRAP;
        default:  state_q <= S_TRAP;
      endcase
    end
  end

  // Moore decode of the control word; FETCH handshake and BRANCH pc_write look at inputs
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    i_or_d        = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_raw = 1'b1;
        i_or_d       = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        reg_dst       = 2'b00;
      end
      S_MEM_WR: begin
        mem_write_raw = 1'b1;
        i_or_d        = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_RTYPE;
        reg_write_raw = 1'b1;
        reg_dst       = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = ALU_SUB;
        pc_source    = 2'b01;
        pc_write_raw = (op_q == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_source    = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_alu_op;
      end
      S_I_WB: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        alu_op        = imm_alu_op;
        reg_write_raw = 1'b1;
        reg_dst       = 2'b00;
      end
      S_JAL: begin
        reg_write_raw = 1'b1;
        reg_dst       = 2'b10;
        pc_source     = 2'b10;
        pc_write_raw  = 1'b1;
      end
      S_JR: begin
        alu_src_a    = 1'b1;
        pc_source    = 2'b11;
        pc_write_raw = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pc_write   = pc_write_raw  & ~reset;
  assign ir_write   = ir_write_raw  & ~reset;
  assign mem_read   = mem_read_raw  & ~reset;
  assign mem_write  = mem_write_raw & ~reset;
  assign reg_write  = reg_write_raw & ~reset;
  assign state      = state_q;
  assign illegal_op = illegal_q;
  assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven vectors for multicycle_control plus
// hand-written memory-timeout sequences. Honours MC_CONTROL_JR_EN like the DUT.
module tb_multicycle_control;

  localparam int D = -1;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       illegal_op;
  logic       bus_error;

  int checks;
  int passes;

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [19:0] exp;
    logic [19:0] care;
  } vec_t;

  vec_t vecs[$];

  multicycle_control #(
    .OP_WIDTH(6),
    .ALUOP_WIDTH(3),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .funct(funct),
    .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(pc_write),
    .ir_write(ir_write),
    .i_or_d(i_or_d),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_to_reg(mem_to_reg),
    .reg_write(reg_write),
    .reg_dst(reg_dst),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .pc_source(pc_source),
    .state(state),
    .illegal_op(illegal_op),
    .bus_error(bus_error)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Build one vector; any expectation given as D is ignored in the comparison.
  // Strobe field order: {pc_write, ir_write, mem_read, mem_write, reg_write}.
  function automatic vec_t mk(string name, int rst, int op, int fn, int z, int mr,
                              int st, int strb, int iod, int m2r, int rdst,
                              int aop, int psrc, int flg);
    vec_t v;
    v.name = name;
    v.rst  = rst[0];
    v.op   = op[5:0];
    v.fn   = fn[5:0];
    v.z    = z[0];
    v.mr   = mr[0];
    v.exp  = {st[3:0], strb[4:0], iod[0], m2r[0], rdst[1:0], aop[2:0], psrc[1:0], flg[1:0]};
    v.care = {(st   >= 0) ? 4'hf     : 4'h0,
              (strb >= 0) ? 5'h1f    : 5'h0,
              (iod  >= 0) ? 1'b1     : 1'b0,
              (m2r  >= 0) ? 1'b1     : 1'b0,
              (rdst >= 0) ? 2'b11    : 2'b00,
              (aop  >= 0) ? 3'b111   : 3'b000,
              (psrc >= 0) ? 2'b11    : 2'b00,
              (flg  >= 0) ? 2'b11    : 2'b00};
    return v;
  endfunction

  function automatic logic [19:0] packOutputs();
    return {state, pc_write, ir_write, mem_read, mem_write, reg_write,
            i_or_d, mem_to_reg, reg_dst, alu_op, pc_source, illegal_op, bus_error};
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset     = v.rst;
    opcode    = v.op;
    funct     = v.fn;
    zero      = v.z;
    mem_ready = v.mr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    passes    = 0;
    reset     = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h20;
    zero      = 1'b0;
    mem_ready = 1'b1;

    //                 name            rst op    fn    z  mr  st  strobes   iod m2r rdst aop psrc flg
    vecs.push_back(mk("reset_hold",    1, 'h00,'h20, 0, 1,  0, 'b00000,  D,  D,  D,   D,  D,   0));
    // R-type: 0,1,6,7
    vecs.push_back(mk("r_fetch",       0, 'h00,'h20, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("r_decode",      0, 'h00,'h20, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("r_exec",        0, 'h00,'h20, 0, 1,  6, 'b00000,  D,  D,  D,   7,  D,   0));
    vecs.push_back(mk("r_wb",          0, 'h00,'h20, 0, 1,  7, 'b00001,  D,  0,  1,   7,  D,   0));
    // LW with three wait cycles in MEM_RD
    vecs.push_back(mk("lw_fetch",      0, 'h23,'h00, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("lw_decode",     0, 'h23,'h00, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("lw_addr",       0, 'h23,'h00, 0, 1,  2, 'b00000,  D,  D,  D,   D,  D,   0));
    vecs.push_back(mk("lw_rd_wait1",   0, 'h23,'h00, 0, 0,  3, 'b00100,  1,  D,  D,   D,  D,   0));
    vecs.push_back(mk("lw_rd_wait2",   0, 'h23,'h00, 0, 0,  3, 'b00100,  1,  D,  D,   D,  D,   0));
    vecs.push_back(mk("lw_rd_wait3",   0, 'h23,'h00, 0, 0,  3, 'b00100,  1,  D,  D,   D,  D,   0));
    vecs.push_back(mk("lw_rd_done",    0, 'h23,'h00, 0, 1,  3, 'b00100,  1,  D,  D,   D,  D,   0));
    vecs.push_back(mk("lw_wb",         0, 'h23,'h00, 0, 1,  4, 'b00001,  D,  1,  0,   D,  D,   0));
    // SW: 0,1,2,5
    vecs.push_back(mk("sw_fetch",      0, 'h2b,'h00, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("sw_decode",     0, 'h2b,'h00, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("sw_addr",       0, 'h2b,'h00, 0, 1,  2, 'b00000,  D,  D,  D,   D,  D,   0));
    vecs.push_back(mk("sw_wr",         0, 'h2b,'h00, 0, 1,  5, 'b00010,  1,  D,  D,   D,  D,   0));
    // BEQ not taken, BNE taken, BEQ taken
    vecs.push_back(mk("beq_fetch",     0, 'h04,'h00, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("beq_decode",    0, 'h04,'h00, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("beq_z0",        0, 'h04,'h00, 0, 1,  8, 'b00000,  D,  D,  D,   2,  1,   0));
    vecs.push_back(mk("bne_fetch",     0, 'h05,'h00, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("bne_decode",    0, 'h05,'h00, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("bne_z0",        0, 'h05,'h00, 0, 1,  8, 'b10000,  D,  D,  D,   2,  1,   0));
    vecs.push_back(mk("beq2_fetch",    0, 'h04,'h00, 1, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("beq2_decode",   0, 'h04,'h00, 1, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("beq_z1",        0, 'h04,'h00, 1, 1,  8, 'b10000,  D,  D,  D,   2,  1,   0));
    // J and JAL
    vecs.push_back(mk("j_fetch",       0, 'h02,'h00, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("j_decode",      0, 'h02,'h00, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("jump",          0, 'h02,'h00, 0, 1,  9, 'b10000,  D,  D,  D,   D,  2,   0));
    vecs.push_back(mk("jal_fetch",     0, 'h03,'h00, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("jal_decode",    0, 'h03,'h00, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("jal",           0, 'h03,'h00, 0, 1, 12, 'b10001,  D,  0,  2,   D,  2,   0));
    // Immediate instructions: ORI, LUI, ANDI
    vecs.push_back(mk("ori_fetch",     0, 'h0d,'h00, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("ori_decode",    0, 'h0d,'h00, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("ori_exec",      0, 'h0d,'h00, 0, 1, 10, 'b00000,  D,  D,  D,   1,  D,   0));
    vecs.push_back(mk("ori_wb",        0, 'h0d,'h00, 0, 1, 11, 'b00001,  D,  0,  0,   1,  D,   0));
    vecs.push_back(mk("lui_fetch",     0, 'h0f,'h00, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("lui_decode",    0, 'h0f,'h00, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("lui_exec",      0, 'h0f,'h00, 0, 1, 10, 'b00000,  D,  D,  D,   5,  D,   0));
    vecs.push_back(mk("lui_wb",        0, 'h0f,'h00, 0, 1, 11, 'b00001,  D,  0,  0,   5,  D,   0));
    vecs.push_back(mk("andi_fetch",    0, 'h0c,'h00, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("andi_decode",   0, 'h0c,'h00, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("andi_exec",     0, 'h0c,'h00, 0, 1, 10, 'b00000,  D,  D,  D,   0,  D,   0));
    vecs.push_back(mk("andi_wb",       0, 'h0c,'h00, 0, 1, 11, 'b00001,  D,  0,  0,   0,  D,   0));
    // R-type with funct 0x08
    vecs.push_back(mk("jr_fetch",      0, 'h00,'h08, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("jr_decode",     0, 'h00,'h08, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
`ifdef MC_CONTROL_JR_EN
    vecs.push_back(mk("jr",            0, 'h00,'h08, 0, 1, 13, 'b10000,  D,  D,  D,   D,  3,   0));
`else
    vecs.push_back(mk("f08_r_exec",    0, 'h00,'h08, 0, 1,  6, 'b00000,  D,  D,  D,   7,  D,   0));
    vecs.push_back(mk("f08_r_wb",      0, 'h00,'h08, 0, 1,  7, 'b00001,  D,  0,  1,   7,  D,   0));
`endif
    // Illegal opcode traps until reset
    vecs.push_back(mk("ill_fetch",     0, 'h3f,'h00, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));
    vecs.push_back(mk("ill_decode",    0, 'h3f,'h00, 0, 1,  1, 'b00000,  D,  D,  D,   4,  D,   0));
    vecs.push_back(mk("ill_trap",      0, 'h3f,'h00, 0, 1, 14, 'b00000,  D,  D,  D,   D,  D,   2));
    vecs.push_back(mk("ill_trap_hold", 0, 'h00,'h00, 1, 1, 14, 'b00000,  D,  D,  D,   D,  D,   2));
    vecs.push_back(mk("ill_trap_hold2",0, 'h00,'h00, 0, 1, 14, 'b00000,  D,  D,  D,   D,  D,   2));
    vecs.push_back(mk("ill_reset",     1, 'h00,'h20, 0, 1, 14, 'b00000,  D,  D,  D,   D,  D,   D));
    vecs.push_back(mk("ill_cleared",   0, 'h00,'h20, 0, 1,  0, 'b11100,  0,  D,  D,   4,  0,   0));

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i].name, 32'(packOutputs() & vecs[i].care),
                  32'(vecs[i].exp & vecs[i].care));
    end

    // Fetch with mem_ready stuck low: 15 wait cycles then TRAP with bus_error
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h20;
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("to_wait1_state", 32'(state), 32'd0);
    checkOutput("to_wait1_alu_src_b", 32'(alu_src_b), 32'd1);
    checkOutput("to_wait1_ir_write", 32'(ir_write), 32'd0);
    repeat (14) @(negedge clk);
    #1;
    checkOutput("to_wait15_state", 32'(state), 32'd0);
    checkOutput("to_wait15_bus_error", 32'(bus_error), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("to_trap_state", 32'(state), 32'd14);
    checkOutput("to_trap_bus_error", 32'(bus_error), 32'd1);
    checkOutput("to_trap_strobes",
                32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'd0);
    checkOutput("to_trap_illegal_op", 32'(illegal_op), 32'd0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checkOutput("to_trap_hold_state", 32'(state), 32'd14);
    checkOutput("to_trap_hold_bus_error", 32'(bus_error), 32'd1);

    // Same fetch, but mem_ready arrives on the 15th wait cycle and wins
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("late_reset_bus_error", 32'(bus_error), 32'd0);
    repeat (14) @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checkOutput("late_ready_state", 32'(state), 32'd0);
    checkOutput("late_ready_ir_write", 32'(ir_write), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("late_decode_state", 32'(state), 32'd1);
    checkOutput("late_decode_alu_src_b", 32'(alu_src_b), 32'd3);
    checkOutput("late_decode_bus_error", 32'(bus_error), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("late_r_exec_state", 32'(state), 32'd6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
